sar_adc_ctrl: RTL and testbench
===============================

# sar_adc_ctrl

Digital sequencer for the on-chip SAR ADC that digitises VIN against VREF. It drives the sample/hold switch and the capacitive DAC trial code, and resolves the comparator decision bit by bit. It hands each finished result to the SPI register block through a valid/ack handshake. It sits in chip_top between the SPI register file (start, mode and timing configuration) and the analog ADC macro (sample switch, DAC, comparator).

## Interface
Parameters:
- NBITS, 10, conversion resolution in bits.
- SCW, 4, width of the sample-time configuration field.

Ports:
- clk  in  1  system clock; every register in the block is clocked on its rising edge.
- res  in  1  reset, synchronous and active-high.
- start  in  1  single-cycle conversion request from the SPI register block.
- cont  in  1  continuous mode: a new conversion begins immediately after each result.
- sample_cycles  in  SCW  length of the sample phase in cycles; a value of 0 is treated as 1.
- avg_log2  in  2  averaging exponent; used only when ADC_AVG_EN is defined.
- comp_in  in  1  comparator output: 1 means VIN is above the DAC voltage for the current trial.
- ack  in  1  result consumed by the register block.
- ovr_clr  in  1  clears the sticky overrun flag.
- sample  out  1  sample/hold switch enable.
- dac_code  out  NBITS  registered DAC trial code.
- busy  out  1  high in every state except IDLE.
- data  out  NBITS  result of the last completed conversion.
- data_valid  out  1  result available; held high until ack.
- overrun  out  1  sticky flag: a result was overwritten before it was acknowledged.

## Operation
- State machine:
  - IDLE → SAMPLE when start=1.
  - SAMPLE → CONVERT after max(sample_cycles,1) cycles.
  - CONVERT → DONE after NBITS cycles.
  - DONE → SAMPLE if cont=1, otherwise DONE → IDLE. DONE lasts one cycle.
- SAMPLE phase: sample=1 and dac_code=0.
- Conversion entry: in the first CONVERT cycle, dac_code has only the MSB set.
- Each CONVERT cycle, for trial bit i:
  - comp_in is sampled at the end of the cycle.
  - Bit i is kept if comp_in=1 and cleared otherwise.
  - Bit i-1 is set as the next trial.
- DONE cycle:
  - The final code is loaded into data.
  - data_valid is set to 1.
  - dac_code returns to 0.
- start while busy=1 is ignored; requests are not queued.
- cont deasserted mid-conversion: the current conversion completes, then the block returns to IDLE.
- ack with data_valid=1 clears data_valid on the next edge.
- New result while data_valid=1 and ack=0: data is overwritten and overrun is set.
- ack in the same cycle as a new result: data_valid stays 1 with the new data, and overrun is not set.
- overrun clears only on ovr_clr=1 or reset. If ovr_clr and a new overrun occur in the same cycle, set wins.
- Configuration inputs (sample_cycles, avg_log2) are latched on leaving IDLE. Changes made while busy have no effect until the next start from IDLE.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset mid-conversion aborts the conversion with no partial result.
- Latency: start is sampled at edge k, and data_valid rises at edge k + S + NBITS + 1, where S = max(sample_cycles,1). With S=4 and NBITS=10 this is 15 cycles.
- Continuous throughput: one result every S + NBITS + 1 cycles.
- comp_in is assumed settled within one cycle of a dac_code change. No synchroniser is used; the comparator is clocked by clk.

## Configuration
- Macro: ADC_AVG_EN.
- Defined:
  - Each result is the average of 2^avg_log2 back-to-back conversions (1, 2, 4 or 8).
  - Conversions are summed in an accumulator of NBITS+3 bits.
  - data = sum >> avg_log2, truncated.
  - data_valid asserts only after the last conversion of the group.
  - SAMPLE is re-entered between conversions of a group without a DONE cycle.
- Not defined: avg_log2 is ignored, every conversion produces a result, and no accumulator is built.

## Structure
- Package sar_adc_pkg holds:
  - the state enum (IDLE, SAMPLE, CONVERT, DONE);
  - the default NBITS and SCW constants;
  - the accumulator width constant NBITS+3.
- Sub-module sar_adc_avg (accumulator, conversion-group counter and shifter) is instantiated only under ADC_AVG_EN.
- The top FSM, bit pointer, sample counter and handshake logic stay in sar_adc_ctrl.

## Test plan
- NBITS=10, S=4, comparator modelling VIN at code 0x2A5, single start → data=0x2A5 and data_valid rises exactly 15 cycles after start; busy is low in the following cycle.
- cont=1, ack pulsed once per result → consecutive results every 15 cycles, no overrun; deasserting cont mid-CONVERT → one more result, then IDLE.
- cont=1, ack never given → overrun=1 after the second result, data holds the latest value; ovr_clr → overrun=0.
- Reset asserted in the 5th CONVERT cycle → next cycle all outputs 0 and state IDLE; a later start yields a correct result.
- Codes 0x000 and 0x3FF, plus a start pulse while busy → exact codes returned; the extra start causes no extra conversion.
- With ADC_AVG_EN, avg_log2=2, comparator codes 100, 101, 102, 103 → data=101, one data_valid after 4 conversions.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared state encoding and sizing constants for the
// SAR ADC sequencer and its optional averaging accumulator.
package sar_adc_pkg;

    localparam int NBITS_DEF = 10;
    localparam int SCW_DEF   = 4;
    localparam int ACC_XTRA  = 3;
    localparam int ACCW_DEF  = NBITS_DEF + ACC_XTRA;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        DONE
    } state_t;

    // Headroom for summing up to eight full-scale conversions.
    function automatic int acc_width(input int nbits);
        return nbits + ACC_XTRA;
    endfunction

endpackage

// File: rtl/sar_adc_ctrl_avg.sv
// sar_adc_avg: sums a group of 2^log2 conversion codes and presents
// the truncated mean; built only when ADC_AVG_EN is defined.
module sar_adc_avg
    import sar_adc_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             clk,
    input  logic             i_res,
    input  logic             i_add,
    input  logic             i_clr,
    input  logic [NBITS-1:0] i_code,
    input  logic [1:0]       i_log2,
    output logic             o_last,
    output logic [NBITS-1:0] o_data
);

    localparam int ACCW = acc_width(NBITS);

    logic [ACCW-1:0] r_acc;
    logic [2:0]      r_cnt;
    logic [2:0]      w_cnt_max;

    assign w_cnt_max = 3'((4'd1 << i_log2) - 4'd1);
    assign o_last    = (r_cnt == w_cnt_max);
    assign o_data    = NBITS'(r_acc >> i_log2);

    always_ff @(posedge clk) begin
        if (i_res || i_clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_add) begin
            r_acc <= r_acc + ACCW'(i_code);
            r_cnt <= r_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: SAR ADC sequencer (sample, bitwise convert, result
// handshake). Define ADC_AVG_EN to average 2^avg_log2 conversions.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int SCW   = SCW_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             cont,
    input  logic [SCW-1:0]   sample_cycles,
    input  logic [1:0]       avg_log2,
    input  logic             comp_in,
    input  logic             ack,
    input  logic             ovr_clr,
    output logic             sample,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic [NBITS-1:0] data,
    output logic             data_valid,
    output logic             overrun
);

    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SCW-1:0]   r_scfg;
    logic [SCW-1:0]   r_scnt;
    logic [SCW-1:0]   w_slast;
    logic [BW-1:0]    r_bit;
    logic [NBITS-1:0] w_mask;
    logic [NBITS-1:0] w_final;
    logic [NBITS-1:0] w_result;
    logic             w_samp_end;
    logic             w_conv_last;
    logic             w_grp_last;
    logic             w_done;
    logic             w_launch;

    // A programmed sample length of 0 behaves as 1.
    assign w_slast     = (r_scfg == '0) ? '0 : r_scfg - 1'b1;
    assign w_samp_end  = (r_state == SAMPLE) && (r_scnt == w_slast);
    assign w_conv_last = (r_state == CONVERT) && (r_bit == '0);
    assign w_done      = (r_state == DONE);
    assign w_launch    = (r_state == IDLE) && start;

    assign w_mask  = NBITS'(1) << r_bit;
    assign w_final = (dac_code & ~w_mask) | (comp_in ? w_mask : '0);

`ifdef ADC_AVG_EN
    logic [1:0] r_avg;

    always_ff @(posedge clk) begin
        if (res) begin
            r_avg <= '0;
        end else if (w_launch) begin
            r_avg <= avg_log2;
        end
    end

    sar_adc_avg #(
        .NBITS (NBITS)
    ) u_avg (
        .clk    (clk),
        .i_res  (res),
        .i_add  (w_conv_last),
        .i_clr  (w_done),
        .i_code (w_final),
        .i_log2 (r_avg),
        .o_last (w_grp_last),
        .o_data (w_result)
    );
`else
    logic w_unused_avg;

    assign w_unused_avg = ^avg_log2;
    assign w_grp_last   = 1'b1;
    assign w_result     = dac_code;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        sample      = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = SAMPLE;
            end
            SAMPLE: begin
                sample = 1'b1;
                if (w_samp_end) w_state_nxt = CONVERT;
            end
            CONVERT: begin
                if (w_conv_last)
                    w_state_nxt = w_grp_last ? DONE : SAMPLE;
            end
            DONE: begin
                w_state_nxt = cont ? SAMPLE : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_scfg   <= '0;
            r_scnt   <= '0;
            r_bit    <= '0;
            dac_code <= '0;
        end else begin
            if (w_launch) r_scfg <= sample_cycles;
            if ((r_state == SAMPLE) && !w_samp_end)
                r_scnt <= r_scnt + 1'b1;
            else
                r_scnt <= '0;
            // Keep/clear the current trial bit, then try the next one down.
            if (w_samp_end) begin
                r_bit    <= BW'(NBITS - 1);
                dac_code <= {1'b1, {(NBITS-1){1'b0}}};
            end else if (r_state == CONVERT) begin
                r_bit <= r_bit - 1'b1;
                if (w_conv_last && !w_grp_last)
                    dac_code <= '0;
                else
                    dac_code <= w_final | (w_mask >> 1);
            end else if (w_done) begin
                dac_code <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            data       <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (w_done) begin
                data       <= w_result;
                data_valid <= 1'b1;
            end else if (ack) begin
                data_valid <= 1'b0;
            end
            // A same-cycle ack consumes the old result, so no overrun.
            if (w_done && data_valid && !ack)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: directed bench with a result scoreboard queue and a
// behavioural comparator that resolves to the code held in vin.
module tb_sar_adc_ctrl;

    localparam int NB = 10;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          res;
    logic          start;
    logic          cont;
    logic [SW-1:0] sample_cycles;
    logic [1:0]    avg_log2;
    logic          comp_in;
    logic          ack;
    logic          ovr_clr;
    logic          sample;
    logic [NB-1:0] dac_code;
    logic          busy;
    logic [NB-1:0] data;
    logic          data_valid;
    logic          overrun;

    logic [NB-1:0] vin;
    logic [NB-1:0] exp_q[$];
    int            total = 0;
    int            bad = 0;
    int unsigned   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign comp_in = (vin >= dac_code);

    sar_adc_ctrl #(
        .NBITS (NB),
        .SCW   (SW)
    ) dut (
        .clk           (clk),
        .res           (res),
        .start         (start),
        .cont          (cont),
        .sample_cycles (sample_cycles),
        .avg_log2      (avg_log2),
        .comp_in       (comp_in),
        .ack           (ack),
        .ovr_clr       (ovr_clr),
        .sample        (sample),
        .dac_code      (dac_code),
        .busy          (busy),
        .data          (data),
        .data_valid    (data_valid),
        .overrun       (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int unsigned t);
        int n;
        n = 0;
        while (data_valid !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, {31'd0, data_valid}, 32'd1);
        t = cyc;
    endtask

    task automatic check_result(input string tag);
        logic [NB-1:0] e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        chk(tag, {22'd0, data}, {22'd0, e});
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sample"}, {31'd0, sample}, 32'd0);
        chk({tag, "_dac"}, {22'd0, dac_code}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_data"}, {22'd0, data}, 32'd0);
        chk({tag, "_valid"}, {31'd0, data_valid}, 32'd0);
        chk({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        int unsigned t0, t1, t2, t3;
        int n;
        res = 1'b1;
        start = 1'b0;
        cont = 1'b0;
        ack = 1'b0;
        ovr_clr = 1'b0;
        sample_cycles = 4'd4;
        avg_log2 = 2'd0;
        vin = '0;
        step(3);
        check_zero("reset");
        res = 1'b0;
        step(1);

        // single conversion, config change while busy ignored
        vin = 10'h2A5;
        exp_q.push_back(vin);
        pulse_start();
        t0 = cyc;
        sample_cycles = 4'd9;
        chk("smp_sample", {31'd0, sample}, 32'd1);
        chk("smp_dac", {22'd0, dac_code}, 32'd0);
        chk("smp_busy", {31'd0, busy}, 32'd1);
        step(4);
        chk("conv_msb", {22'd0, dac_code}, 32'h200);
        chk("conv_sample", {31'd0, sample}, 32'd0);
        wait_valid("t1_valid", t1);
        chk("t1_lat", t1 - t0, 32'd15);
        check_result("t1_data");
        chk("t1_busy", {31'd0, busy}, 32'd0);
        sample_cycles = 4'd4;
        pulse_ack();
        chk("t1_ack", {31'd0, data_valid}, 32'd0);

        // continuous with acks, cont dropped mid-convert
        cont = 1'b1;
        vin = 10'h155;
        exp_q.push_back(vin);
        pulse_start();
        t0 = cyc;
        wait_valid("c1_valid", t1);
        chk("c1_lat", t1 - t0, 32'd15);
        check_result("c1_data");
        vin = 10'h0F0;
        exp_q.push_back(vin);
        pulse_ack();
        chk("c1_ack", {31'd0, data_valid}, 32'd0);
        wait_valid("c2_valid", t2);
        chk("c2_period", t2 - t1, 32'd15);
        check_result("c2_data");
        chk("c2_ovr", {31'd0, overrun}, 32'd0);
        vin = 10'h3C1;
        exp_q.push_back(vin);
        pulse_ack();
        step(5);
        cont = 1'b0;
        wait_valid("c3_valid", t3);
        chk("c3_period", t3 - t2, 32'd15);
        check_result("c3_data");
        chk("c3_ovr", {31'd0, overrun}, 32'd0);
        pulse_ack();
        step(30);
        chk("c_idle_busy", {31'd0, busy}, 32'd0);
        chk("c_idle_valid", {31'd0, data_valid}, 32'd0);

        // overrun when never acked, then ovr_clr
        cont = 1'b1;
        vin = 10'h2A5;
        exp_q.push_back(vin);
        pulse_start();
        wait_valid("o1_valid", t1);
        check_result("o1_data");
        chk("o1_ovr", {31'd0, overrun}, 32'd0);
        vin = 10'h133;
        exp_q.push_back(vin);
        cont = 1'b0;
        step(15);
        chk("o2_valid", {31'd0, data_valid}, 32'd1);
        check_result("o2_data");
        chk("o2_ovr", {31'd0, overrun}, 32'd1);
        step(3);
        chk("o2_sticky", {31'd0, overrun}, 32'd1);
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        chk("o_clr", {31'd0, overrun}, 32'd0);
        chk("o_clr_valid", {31'd0, data_valid}, 32'd1);
        pulse_ack();
        chk("o_ack", {31'd0, data_valid}, 32'd0);

        // ack coincident with a new result
        cont = 1'b1;
        vin = 10'h0AA;
        exp_q.push_back(vin);
        pulse_start();
        wait_valid("a1_valid", t1);
        check_result("a1_data");
        vin = 10'h355;
        exp_q.push_back(vin);
        step(14);
        ack = 1'b1;
        cont = 1'b0;
        step(1);
        ack = 1'b0;
        chk("a2_valid", {31'd0, data_valid}, 32'd1);
        check_result("a2_data");
        chk("a2_ovr", {31'd0, overrun}, 32'd0);
        pulse_ack();
        chk("a2_ack", {31'd0, data_valid}, 32'd0);

        // reset in the 5th convert cycle
        vin = 10'h2A5;
        pulse_start();
        step(8);
        chk("r_busy", {31'd0, busy}, 32'd1);
        res = 1'b1;
        step(1);
        res = 1'b0;
        check_zero("midrst");
        step(1);
        vin = 10'h1C3;
        exp_q.push_back(vin);
        pulse_start();
        t0 = cyc;
        wait_valid("r2_valid", t1);
        chk("r2_lat", t1 - t0, 32'd15);
        check_result("r2_data");
        pulse_ack();

        // extreme codes and a start while busy
        vin = 10'h000;
        exp_q.push_back(vin);
        pulse_start();
        t0 = cyc;
        step(7);
        pulse_start();
        wait_valid("z_valid", t1);
        chk("z_lat", t1 - t0, 32'd15);
        check_result("z_data");
        pulse_ack();
        vin = 10'h3FF;
        exp_q.push_back(vin);
        pulse_start();
        t0 = cyc;
        wait_valid("f_valid", t1);
        chk("f_lat", t1 - t0, 32'd15);
        check_result("f_data");
        pulse_ack();
        step(30);
        chk("x_busy", {31'd0, busy}, 32'd0);
        chk("x_valid", {31'd0, data_valid}, 32'd0);

        // sample_cycles of 0 acts as 1
        sample_cycles = 4'd0;
        vin = 10'h05A;
        exp_q.push_back(vin);
        pulse_start();
        t0 = cyc;
        wait_valid("s0_valid", t1);
        chk("s0_lat", t1 - t0, 32'd12);
        check_result("s0_data");
        pulse_ack();
        sample_cycles = 4'd4;

`ifdef ADC_AVG_EN
        avg_log2 = 2'd2;
        vin = 10'd100;
        exp_q.push_back(10'd101);
        pulse_start();
        t0 = cyc;
        avg_log2 = 2'd0;
        for (int j = 1; j < 4; j++) begin
            n = 0;
            while (sample === 1'b1 && n < 100) begin
                step(1);
                n++;
            end
            while (sample !== 1'b1 && n < 100) begin
                step(1);
                n++;
            end
            vin = NB'(100 + j);
        end
        wait_valid("avg_valid", t1);
        chk("avg_lat", t1 - t0, 32'd57);
        check_result("avg_data");
        pulse_ack();
`endif

        chk("q_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
